button_conditioner: RTL and testbench

Input-conditioning stage between the raw Tang Nano push-buttons and the step sequencer. It synchronises, debounces and edge-detects up to N active-low buttons: the four cursor buttons, the play/edit switch, and the A/B set/clear buttons. It delivers clean active-high levels plus single-cycle press/release strobes, with hold-to-repeat on cursor buttons. The sequencer consumes one press strobe per intended move, independent of its own slow update clock.

---
 rtl/btn_pkg.sv | 31 +++
 rtl/btn_channel.sv | 124 ++++++++++++
 rtl/button_conditioner.sv | 58 +++++
 tb/tb_button_conditioner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice: repeat FSM states,
// 27 MHz default timing and the board's button channel assignment.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  localparam int unsigned DEF_N          = 7;
  localparam int unsigned DEF_TICK_DIV   = 27000;
  localparam int unsigned DEF_DB_TICKS   = 10;
  localparam int unsigned DEF_RPT_DELAY  = 400;
  localparam int unsigned DEF_RPT_PERIOD = 100;
  localparam logic [6:0]  DEF_RPT_MASK   = 7'b0001111;

  localparam int unsigned BTN_RIGHT = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;
  localparam int unsigned BTN_MODE  = 4;
  localparam int unsigned BTN_A     = 5;
  localparam int unsigned BTN_B     = 6;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, tick-based debounce, hold-to-repeat
// FSM and registered press/release strobes.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DB_TICKS   = DEF_DB_TICKS,
  parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  input  logic tick,
  input  logic rpt_en,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned DW = cnt_width(DB_TICKS);
  localparam int unsigned RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned RW = cnt_width(RMAX);

  localparam logic [DW-1:0] DB_LAST    = DW'(DB_TICKS - 1);
  localparam logic [DW-1:0] DB_ONE     = DW'(1);
  localparam logic [RW-1:0] RPT_D_LAST = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RPT_P_LAST = RW'(RPT_PERIOD - 1);
  localparam logic [RW-1:0] RC_ONE     = RW'(1);

  logic [1:0]    sync_q;
  logic          samp;
  logic [DW-1:0] db_q, db_d;
  logic [RW-1:0] rc_q, rc_d;
  logic          level_d, press_d, rel_d;
  logic          accept_press, accept_rel;
  rpt_state_e    state_q, state_d;

  always_comb begin
    samp         = ~sync_q[1];
    db_d         = db_q;
    rc_d         = rc_q;
    level_d      = level;
    state_d      = state_q;
    accept_press = 1'b0;
    accept_rel   = 1'b0;

    if (tick) begin
      if (samp == level) begin
        db_d = '0;
      end else if (db_q == DB_LAST) begin
        db_d         = '0;
        level_d      = samp;
        accept_press = samp;
        accept_rel   = ~samp;
      end else begin
        db_d = db_q + DB_ONE;
      end
    end

    press_d = accept_press;
    rel_d   = accept_rel;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (accept_press && rpt_en) begin
            state_d = DELAY;
            rc_d    = '0;
          end
        end
        DELAY: begin
          if (rc_q == RPT_D_LAST) begin
            state_d = REPEAT;
            rc_d    = '0;
            press_d = 1'b1;
          end else begin
            rc_d = rc_q + RC_ONE;
          end
        end
        REPEAT: begin
          if (rc_q == RPT_P_LAST) begin
            rc_d    = '0;
            press_d = 1'b1;
          end else begin
            rc_d = rc_q + RC_ONE;
          end
        end
        default: state_d = IDLE;
      endcase

      // A release accepted on a repeat-due tick suppresses that repeat.
      if (accept_rel) begin
        state_d = IDLE;
        rc_d    = '0;
        press_d = 1'b0;
      end
    end

    if (!rpt_en) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '1;
      db_q    <= '0;
      rc_q    <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync_q  <= {sync_q[0], raw_n};
      db_q    <= db_d;
      rc_q    <= rc_d;
      level   <= level_d;
      press   <= press_d;
      rel     <= rel_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N active-low raw buttons into clean levels and press/release strobes;
// the shared sampling-tick prescaler lives here, one btn_channel per button.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N          = DEF_N,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned DB_TICKS   = DEF_DB_TICKS,
  parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD,
  parameter logic [N-1:0] RPT_MASK  = N'(DEF_RPT_MASK)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw_n,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  // release strobes; "release" itself is a reserved word
  output logic [N-1:0] rel,
  output logic         tick
);

  localparam int unsigned PW = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_ONE     = PW'(1);

  logic [PW-1:0] pcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else if (pcnt_q == TICK_LAST) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + P_ONE;
    end
  end

  assign tick = (pcnt_q == TICK_LAST);

  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_channel #(
      .DB_TICKS  (DB_TICKS),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw_n (raw_n[i]),
      .tick  (tick),
      .rpt_en(RPT_MASK[i]),
      .level (level[i]),
      .press (press[i]),
      .rel   (rel[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed plus randomized bench for button_conditioner; every cycle is compared
// against a tick-level behavioural model of debounce and hold-to-repeat.
module tb_button_conditioner;

  localparam int N  = 7;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RP = 2;
  localparam logic [N-1:0] MASK = 7'b0001111;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw_n;
  logic [N-1:0] level, press, rel;
  logic         tick;

  button_conditioner #(
    .N         (N),
    .TICK_DIV  (TD),
    .DB_TICKS  (DB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP),
    .RPT_MASK  (MASK)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .raw_n(raw_n),
    .level(level),
    .press(press),
    .rel  (rel),
    .tick (tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: raw history, ticks elapsed, and per-channel debounce / hold age.
  int           m_cyc;
  logic [N-1:0] m_h0, m_h1;
  logic [N-1:0] m_lvl, m_press, m_rel;
  int           m_db[N];
  int           m_held[N];

  int ncyc;
  int pc[N], rc[N], first[N];

  task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, ncyc, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, ncyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_cyc   = 0;
    m_h0    = '1;
    m_h1    = '1;
    m_lvl   = '0;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) begin
      m_db[i]   = 0;
      m_held[i] = -1;
    end
  endtask

  // One clock edge: the sample seen is the raw value from two edges back.
  task automatic model_edge();
    logic [N-1:0] s;
    bit tk;
    s  = ~m_h1;
    tk = (m_cyc % TD == TD - 1);
    m_cyc++;
    m_press = '0;
    m_rel   = '0;
    if (tk) begin
      for (int i = 0; i < N; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_db[i]++;
          if (m_db[i] == DB) begin
            m_db[i]  = 0;
            m_lvl[i] = s[i];
            if (s[i]) begin
              m_press[i] = 1'b1;
              m_held[i]  = MASK[i] ? 0 : -1;
            end else begin
              m_rel[i]  = 1'b1;
              m_held[i] = -1;
            end
          end
        end else begin
          m_db[i] = 0;
        end
        if (!m_press[i] && m_held[i] >= 0) begin
          m_held[i]++;
          if (m_held[i] >= RD && (m_held[i] - RD) % RP == 0) m_press[i] = 1'b1;
        end
      end
    end
    m_h1 = m_h0;
    m_h0 = raw_n;
  endtask

  task automatic clear_counts();
    ncyc = 0;
    for (int i = 0; i < N; i++) begin
      pc[i]    = 0;
      rc[i]    = 0;
      first[i] = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_edge();
    else model_clear();
    @(negedge clk);
    if (!rst) model_clear();
    ncyc++;
    chk_vec("level", level, m_lvl);
    chk_vec("press", press, m_press);
    chk_vec("release", rel, m_rel);
    chk_bit("tick", tick, rst && (m_cyc % TD == TD - 1));
    for (int i = 0; i < N; i++) begin
      if (press[i] === 1'b1) begin
        pc[i]++;
        if (first[i] == 0) first[i] = ncyc;
      end
      if (rel[i] === 1'b1) rc[i]++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    rst   = 1'b0;
    raw_n = '1;
    model_clear();
    clear_counts();
    run(3);
    chk_vec("reset_level", level, '0);

    rst = 1'b1;
    clear_counts();
    run(2);
    chk_bit("tick_not_yet", tick, 1'b0);
    run(1);
    chk_bit("tick_first_clk3", tick, 1'b1);
    run(9);

    // Clean press with auto-repeat, then release.
    clear_counts();
    raw_n[0] = 1'b0;
    run(100);
    chk_int("ch0_latency_ok", int'(first[0] >= 1 && first[0] <= 2 + DB * TD), 1);
    raw_n[0] = 1'b1;
    clear_counts();
    run(40);
    chk_int("ch0_release_count", rc[0], 1);

    // Short glitch on a non-repeat channel.
    clear_counts();
    raw_n[5] = 1'b0;
    run(6);
    raw_n[5] = 1'b1;
    run(30);
    chk_int("ch5_glitch_strobes", pc[5] + rc[5], 0);
    chk_bit("ch5_glitch_level", level[5], 1'b0);

    // Long hold on a channel without repeat.
    clear_counts();
    raw_n[6] = 1'b0;
    run(100);
    raw_n[6] = 1'b1;
    run(40);
    chk_int("ch6_single_press", pc[6], 1);

    // Simultaneous presses.
    clear_counts();
    raw_n[2:1] = 2'b00;
    run(24);
    raw_n[2:1] = 2'b11;
    run(40);
    chk_int("ch1_pressed", int'(first[1] > 0), 1);
    chk_int("ch1_ch2_same_cycle", first[2], first[1]);

    // Reset while repeating with the button still held.
    raw_n[3] = 1'b0;
    run(60);
    rst = 1'b0;
    #1;
    chk_vec("async_rst_level", level, '0);
    chk_vec("async_rst_press", press, '0);
    chk_vec("async_rst_release", rel, '0);
    chk_bit("async_rst_tick", tick, 1'b0);
    run(3);
    rst = 1'b1;
    clear_counts();
    run(16);
    chk_int("ch3_reacquire_count", pc[3], 1);
    chk_int("ch3_reacquire_cycle", first[3], 12);
    run(17);
    chk_int("ch3_repeat_resumed", pc[3], 2);
    raw_n[3] = 1'b1;
    run(40);

    // Random bouncing with varying activity levels.
    for (int r = 0; r < 20; r++) begin
      int p;
      p = int'($urandom_range(2, 40));
      for (int c = 0; c < 50; c++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, p - 1) == 0) raw_n[i] = ~raw_n[i];
        end
        cyc();
      end
    end
    raw_n = '1;
    run(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
